// File: rtl/dffrsnq_pipe.sv
// WIDTH-bit, DEPTH-stage register chain with sync reset, sync active-low preset,
// advance enable, per-stage valid tracking and a registered occupancy counter.
module dffrsnq_pipe #(
    parameter int              WIDTH    = 8,
    parameter int              DEPTH    = 2,
    parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL  = {WIDTH{1'b1}},
    parameter bit              INVERT_Q = 1'b0,
    localparam int             OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SETN,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VLD,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             Q_VLD,
    output logic [OCC_W-1:0] OCC
);

    // Valid semantics: D_VLD qualifies D on an enabled edge; invalid words still
    // shift through the chain, and vld_q only records which stages hold real data.
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [WIDTH-1:0] q_w;

    // Preset beats advance; reset is applied in the register process and beats both.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        occ_d  = occ_q;
        if (!SETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = SET_VAL;
            end
            vld_d = {DEPTH{1'b1}};
            occ_d = OCC_W'(DEPTH);
        end else if (EN) begin
            data_d[0] = D;
            vld_d[0]  = D_VLD;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            // Entering valid minus leaving valid keeps the count equal to popcount(vld_q).
            occ_d = occ_q + OCC_W'(D_VLD) - OCC_W'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= INIT_VAL;
            end
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    assign q_w   = INVERT_Q ? ~data_q[DEPTH-1] : data_q[DEPTH-1];
    assign Q     = q_w;
    assign QN    = ~q_w;
    assign Q_VLD = vld_q[DEPTH-1];
    assign OCC   = occ_q;

endmodule

// File: tb/tb_dffrsnq_pipe.sv
// Bench for dffrsnq_pipe: three configurations driven in lockstep and compared
// against a queue-based model of the register chain.
module tb_dffrsnq_pipe;

  typedef logic [8:0] wq_t [$];  // {vld, data}; index 0 = stage 0, last = output stage

  localparam logic [7:0] INIT = 8'h00;
  localparam logic [7:0] SETV = 8'h3C;

  logic       clk;
  logic       rst, setn, en, dvld;
  logic [7:0] d;

  logic [7:0] q0, qn0, q1, qn1, q2, qn2;
  logic       qv0, qv1, qv2;
  logic [1:0] occ0, occ1;
  logic [0:0] occ2;

  int total = 0;
  int bad   = 0;

  wq_t exp_q0, exp_q1, exp_q2;

  // ---------------- clock / DUTs ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dffrsnq_pipe #(.WIDTH(8), .DEPTH(2), .INIT_VAL(INIT), .SET_VAL(SETV), .INVERT_Q(1'b0)) u_d2 (
    .CLK(clk), .RST(rst), .SETN(setn), .EN(en), .D(d), .D_VLD(dvld),
    .Q(q0), .QN(qn0), .Q_VLD(qv0), .OCC(occ0));

  dffrsnq_pipe #(.WIDTH(8), .DEPTH(3), .INIT_VAL(INIT), .SET_VAL(SETV), .INVERT_Q(1'b0)) u_d3 (
    .CLK(clk), .RST(rst), .SETN(setn), .EN(en), .D(d), .D_VLD(dvld),
    .Q(q1), .QN(qn1), .Q_VLD(qv1), .OCC(occ1));

  dffrsnq_pipe #(.WIDTH(8), .DEPTH(1), .INIT_VAL(INIT), .SET_VAL(SETV), .INVERT_Q(1'b1)) u_d1 (
    .CLK(clk), .RST(rst), .SETN(setn), .EN(en), .D(d), .D_VLD(dvld),
    .Q(q2), .QN(qn2), .Q_VLD(qv2), .OCC(occ2));

  // ---------------- reference model ----------------
  function automatic wq_t model_next(wq_t q, int depth, logic r, logic s, logic e,
                                     logic [7:0] dd, logic dv);
    wq_t n;
    n = q;
    if (r) begin
      n = {};
      repeat (depth) n.push_back({1'b0, INIT});
    end else if (!s) begin
      n = {};
      repeat (depth) n.push_back({1'b1, SETV});
    end else if (e) begin
      n.push_front({dv, dd});
      void'(n.pop_back());
    end
    return n;
  endfunction

  function automatic logic [7:0] m_q(wq_t q, bit inv);
    logic [8:0] last;
    last = q[q.size()-1];
    return inv ? ~last[7:0] : last[7:0];
  endfunction

  function automatic logic m_vld(wq_t q);
    logic [8:0] last;
    last = q[q.size()-1];
    return last[8];
  endfunction

  function automatic int m_occ(wq_t q);
    int c;
    logic [8:0] w;
    c = 0;
    foreach (q[i]) begin
      w = q[i];
      if (w[8]) c++;
    end
    return c;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d2_q",   {24'h0, q0},   {24'h0, m_q(exp_q0, 1'b0)});
    chk("d2_qn",  {24'h0, qn0},  {24'h0, ~m_q(exp_q0, 1'b0)});
    chk("d2_vld", {31'h0, qv0},  {31'h0, m_vld(exp_q0)});
    chk("d2_occ", {30'h0, occ0}, m_occ(exp_q0));
    chk("d3_q",   {24'h0, q1},   {24'h0, m_q(exp_q1, 1'b0)});
    chk("d3_qn",  {24'h0, qn1},  {24'h0, ~m_q(exp_q1, 1'b0)});
    chk("d3_vld", {31'h0, qv1},  {31'h0, m_vld(exp_q1)});
    chk("d3_occ", {30'h0, occ1}, m_occ(exp_q1));
    chk("d1_q",   {24'h0, q2},   {24'h0, m_q(exp_q2, 1'b1)});
    chk("d1_qn",  {24'h0, qn2},  {24'h0, ~m_q(exp_q2, 1'b1)});
    chk("d1_vld", {31'h0, qv2},  {31'h0, m_vld(exp_q2)});
    chk("d1_occ", {31'h0, occ2}, m_occ(exp_q2));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic s, input logic e,
                       input logic [7:0] dd, input logic dv);
    rst  = r;
    setn = s;
    en   = e;
    d    = dd;
    dvld = dv;
    @(posedge clk);
    exp_q0 = model_next(exp_q0, 2, r, s, e, dd, dv);
    exp_q1 = model_next(exp_q1, 3, r, s, e, dd, dv);
    exp_q2 = model_next(exp_q2, 1, r, s, e, dd, dv);
    @(negedge clk);
    check_all();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0; setn = 1'b1; en = 1'b0; d = '0; dvld = 1'b0;
    @(negedge clk);

    // reset values
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_q",   {24'h0, q0},   32'h00);
    chk("rst_qn",  {24'h0, qn0},  32'hFF);
    chk("rst_vld", {31'h0, qv0},  32'h0);
    chk("rst_occ", {30'h0, occ0}, 32'h0);

    // latency on the 3-deep chain
    cycle(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1);
    chk("lat_occ_e0", {30'h0, occ1}, 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    chk("lat_occ_e1", {30'h0, occ1}, 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    chk("lat_q_e2",   {24'h0, q1},   32'hA5);
    chk("lat_vld_e2", {31'h0, qv1},  32'd1);
    chk("lat_occ_e2", {30'h0, occ1}, 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    chk("lat_occ_e3", {30'h0, occ1}, 32'd0);

    // hold and occupancy on the 2-deep chain
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 8'h11, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'($urandom), 1'($urandom));
      chk("hold_q",   {24'h0, q0},   32'h11);
      chk("hold_occ", {30'h0, occ0}, 32'd2);
    end
    cycle(1'b0, 1'b1, 1'b1, 8'h99, 1'b0);
    chk("drain_q",   {24'h0, q0},   32'h22);
    chk("drain_occ", {30'h0, occ0}, 32'd1);

    // preset ignores D/EN, then drains with decreasing occupancy
    cycle(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
    chk("set_q",   {24'h0, q0},   32'h3C);
    chk("set_vld", {31'h0, qv0},  32'd1);
    chk("set_occ", {30'h0, occ0}, 32'd2);
    cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    chk("set_dr1_occ", {30'h0, occ0}, 32'd1);
    chk("set_dr1_q",   {24'h0, q0},   32'h3C);
    cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    chk("set_dr2_occ", {30'h0, occ0}, 32'd0);

    // reset wins over preset
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
    chk("prio_q",   {24'h0, q0},   32'h00);
    chk("prio_occ", {30'h0, occ0}, 32'd0);

    // inverted output, single stage, mid-stream reset
    cycle(1'b0, 1'b1, 1'b1, 8'h0F, 1'b1);
    chk("inv_q",  {24'h0, q2},  32'hF0);
    chk("inv_qn", {24'h0, qn2}, 32'h0F);
    cycle(1'b1, 1'b1, 1'b1, 8'h33, 1'b1);
    chk("inv_rst_q",   {24'h0, q2}, 32'hFF);
    chk("inv_rst_vld", {31'h0, qv2}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 19) != 0),
            1'($urandom_range(0, 3) != 0),
            8'($urandom),
            1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
